// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants, FSM/op enums and BCD helpers for the DS1307 time reader.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package rtc_pkg;

   localparam logic [6:0] DS1307_ADDR = 7'h68;
   localparam logic [7:0] REG_SEC     = 8'h00;
   localparam logic [7:0] REG_MIN     = 8'h01;
   localparam logic [7:0] REG_HOUR    = 8'h02;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UPDATE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OP_READ     = 2'd0,
      OP_CH_CLEAR = 2'd1,
      OP_SET      = 2'd2
   } op_e;

   // Two BCD digits to binary; no range checking here.
   function automatic logic [6:0] bcd_val(input logic [3:0] tens, input logic [3:0] units);
      return 7'(tens) * 7'd10 + 7'(units);
   endfunction

   // Binary 0..63 to packed BCD using a compare chain for the tens digit.
   function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
      logic [3:0] tens;
      logic [3:0] units;
      if (v >= 6'd60)      tens = 4'd6;
      else if (v >= 6'd50) tens = 4'd5;
      else if (v >= 6'd40) tens = 4'd4;
      else if (v >= 6'd30) tens = 4'd3;
      else if (v >= 6'd20) tens = 4'd2;
      else if (v >= 6'd10) tens = 4'd1;
      else                 tens = 4'd0;
      units = 4'(v - 6'(tens) * 6'd10);
      return {tens, units};
   endfunction

endpackage

// File: rtl/rtc_time_reader_bcd_decode.sv
// rtc_bcd_decode: DS1307 raw seconds/minutes/hours registers to binary 24 h time.
// Latency: combinational.
// Backpressure: none; bcd_err flags any digit > 9 or value out of range.
// Ports: raw_sec/raw_min/raw_hour in (CH / unused bit 7 stripped), sec/min/hour out, bcd_err out.
module rtc_bcd_decode
   import rtc_pkg::*;
(
   input  logic [6:0] raw_sec,
   input  logic [6:0] raw_min,
   input  logic [6:0] raw_hour,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic       bcd_err
);
   logic [6:0] sec_full;
   logic [6:0] min_full;
   logic [6:0] hour_full;
   logic [6:0] h12;
   logic       mode12;
   logic       pm;

   always_comb begin
      sec_full  = bcd_val({1'b0, raw_sec[6:4]}, raw_sec[3:0]);
      min_full  = bcd_val({1'b0, raw_min[6:4]}, raw_min[3:0]);
      mode12    = raw_hour[6];
      pm        = raw_hour[5];
      h12       = bcd_val({3'b000, raw_hour[4]}, raw_hour[3:0]);
      hour_full = bcd_val({2'b00, raw_hour[5:4]}, raw_hour[3:0]);
      if (mode12) begin
         // 12 AM is midnight, 12 PM is noon; other PM hours shift by 12.
         if (h12 == 7'd12) hour_full = pm ? 7'd12 : 7'd0;
         else              hour_full = pm ? h12 + 7'd12 : h12;
      end
      bcd_err = (raw_sec[3:0] > 4'd9) || (raw_min[3:0] > 4'd9) || (raw_hour[3:0] > 4'd9) ||
                (sec_full > 7'd59) || (min_full > 7'd59) || (hour_full > 7'd23) ||
                (mode12 && ((h12 == 7'd0) || (h12 > 7'd12)));
      sec  = sec_full[5:0];
      min  = min_full[5:0];
      hour = hour_full[4:0];
   end

endmodule

// File: rtl/rtc_time_reader.sv
// rtc_time_reader: polls DS1307 sec/min/hour via the I2C master, presents coherent binary time; serves time-set writes.
// Latency: done edge -> next i2c_start 2 clk; last done edge -> new_time 2 clk.
// Backpressure: one transaction in flight, next issued only after done edge or timeout; set_req latched, never dropped.
// Ports: clk/rst; set_req/set_hour/set_min from UI; i2c_* to/from master; hours/minutes/seconds/time_valid/new_time
//        to scheduler; busy (not IDLE), err (timeout or bad BCD).
module rtc_time_reader
   import rtc_pkg::*;
#(
   parameter int POLL_CYCLES    = 50_000_000,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_req,
   input  logic [4:0] set_hour,
   input  logic [5:0] set_min,
   output logic       i2c_start,
   output logic       i2c_rw,
   output logic [6:0] i2c_addr,
   output logic [7:0] i2c_reg_addr,
   output logic [7:0] i2c_wdata,
   input  logic [7:0] i2c_rdata,
   input  logic       i2c_done,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       time_valid,
   output logic       new_time,
   output logic       busy,
   output logic       err
);
   localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [1:0]      step_q, step_d;
   logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            poll_pend_q, poll_pend_d;
   logic            set_pend_q, set_pend_d;
   logic [7:0]      set_hour_bcd_q, set_hour_bcd_d;
   logic [7:0]      set_min_bcd_q, set_min_bcd_d;
   logic            ch_done_q, ch_done_d;
   logic            done_q, done_d;
   logic [7:0]      raw_sec_q, raw_sec_d;
   logic [6:0]      raw_min_q, raw_min_d;
   logic [6:0]      raw_hour_q, raw_hour_d;
   logic            start_q, start_d;
   logic            rw_q, rw_d;
   logic [7:0]      reg_addr_q, reg_addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [4:0]      hours_q, hours_d;
   logic [5:0]      minutes_q, minutes_d;
   logic [5:0]      seconds_q, seconds_d;
   logic            time_valid_q, time_valid_d;
   logic            new_time_q, new_time_d;
   logic            err_q, err_d;

   logic            done_edge;
   logic            poll_wrap;
   logic [5:0]      dec_sec;
   logic [5:0]      dec_min;
   logic [4:0]      dec_hour;
   logic            dec_err;

   rtc_bcd_decode u_decode (
      .raw_sec  (raw_sec_q[6:0]),
      .raw_min  (raw_min_q),
      .raw_hour (raw_hour_q),
      .sec      (dec_sec),
      .min      (dec_min),
      .hour     (dec_hour),
      .bcd_err  (dec_err)
   );

   // A level that is already high when WAIT is entered is not a completion.
   assign done_edge = i2c_done & ~done_q;
   assign poll_wrap = (poll_cnt_q == POLL_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (set_pend_q || poll_pend_q) state_d = ST_ISSUE;
         ST_ISSUE:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (done_edge) begin
               if (step_q != 2'd2)       state_d = ST_ISSUE;
               else if (op_q == OP_READ) state_d = ST_UPDATE;
               else                      state_d = ST_IDLE;
            end else if (tmo_cnt_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         ST_UPDATE: state_d = (raw_sec_q[7] && !ch_done_q) ? ST_ISSUE : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      op_d           = op_q;
      step_d         = step_q;
      poll_cnt_d     = poll_wrap ? '0 : poll_cnt_q + PW'(1);
      tmo_cnt_d      = tmo_cnt_q;
      poll_pend_d    = poll_pend_q;
      set_pend_d     = set_pend_q;
      set_hour_bcd_d = set_hour_bcd_q;
      set_min_bcd_d  = set_min_bcd_q;
      ch_done_d      = ch_done_q;
      done_d         = i2c_done;
      raw_sec_d      = raw_sec_q;
      raw_min_d      = raw_min_q;
      raw_hour_d     = raw_hour_q;
      start_d        = 1'b0;
      rw_d           = rw_q;
      reg_addr_d     = reg_addr_q;
      wdata_d        = wdata_q;
      hours_d        = hours_q;
      minutes_d      = minutes_q;
      seconds_d      = seconds_q;
      time_valid_d   = time_valid_q;
      new_time_d     = 1'b0;
      err_d          = err_q;

      case (state_q)
         ST_IDLE: begin
            step_d = 2'd0;
            if (set_pend_q) begin
               op_d = OP_SET;
            end else if (poll_pend_q) begin
               op_d        = OP_READ;
               poll_pend_d = 1'b0;
            end
         end
         ST_ISSUE: begin
            start_d   = 1'b1;
            tmo_cnt_d = TMO_LOAD;
            rw_d      = (op_q == OP_READ);
            // SET writes hour first so minute/second land last; CH_CLEAR only ever runs step 2.
            case (step_q)
               2'd0:    reg_addr_d = (op_q == OP_SET) ? REG_HOUR : REG_SEC;
               2'd1:    reg_addr_d = REG_MIN;
               default: reg_addr_d = (op_q == OP_READ) ? REG_HOUR : REG_SEC;
            endcase
            if (op_q == OP_SET && step_q == 2'd0)      wdata_d = set_hour_bcd_q;
            else if (op_q == OP_SET && step_q == 2'd1) wdata_d = set_min_bcd_q;
            else                                       wdata_d = 8'h00;
         end
         ST_WAIT: begin
            if (done_edge) begin
               if (op_q == OP_READ) begin
                  case (step_q)
                     2'd0:    raw_sec_d  = i2c_rdata;
                     2'd1:    raw_min_d  = i2c_rdata[6:0];
                     default: raw_hour_d = i2c_rdata[6:0];
                  endcase
               end
               if (step_q != 2'd2)          step_d     = step_q + 2'd1;
               else if (op_q == OP_SET)      set_pend_d = 1'b0;
               else if (op_q == OP_CH_CLEAR) ch_done_d  = 1'b1;
            end else if (tmo_cnt_q == '0) begin
               // Abort; pending flags stay as they are so the work is retried.
               err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q - TW'(1);
            end
         end
         ST_UPDATE: begin
            if (raw_sec_q[7] && !ch_done_q) begin
               // Oscillator halted: start it once, publish nothing from this read.
               op_d   = OP_CH_CLEAR;
               step_d = 2'd2;
            end else if (dec_err) begin
               err_d = 1'b1;
            end else begin
               hours_d      = dec_hour;
               minutes_d    = dec_min;
               seconds_d    = dec_sec;
               time_valid_d = 1'b1;
               new_time_d   = 1'b1;
               err_d        = 1'b0;
            end
         end
         default: ;
      endcase

      // Late so a new request wins over completion of the previous one.
      if (set_req) begin
         set_pend_d     = 1'b1;
         set_hour_bcd_d = bin_to_bcd({1'b0, set_hour});
         set_min_bcd_d  = bin_to_bcd(set_min);
      end
      if (poll_wrap) poll_pend_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q           <= OP_READ;
         step_q         <= 2'd0;
         poll_cnt_q     <= '0;
         tmo_cnt_q      <= '0;
         poll_pend_q    <= 1'b1;
         set_pend_q     <= 1'b0;
         set_hour_bcd_q <= 8'h00;
         set_min_bcd_q  <= 8'h00;
         ch_done_q      <= 1'b0;
         done_q         <= 1'b0;
         raw_sec_q      <= 8'h00;
         raw_min_q      <= 7'h00;
         raw_hour_q     <= 7'h00;
         start_q        <= 1'b0;
         rw_q           <= 1'b0;
         reg_addr_q     <= 8'h00;
         wdata_q        <= 8'h00;
         hours_q        <= 5'd0;
         minutes_q      <= 6'd0;
         seconds_q      <= 6'd0;
         time_valid_q   <= 1'b0;
         new_time_q     <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         op_q           <= op_d;
         step_q         <= step_d;
         poll_cnt_q     <= poll_cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
         poll_pend_q    <= poll_pend_d;
         set_pend_q     <= set_pend_d;
         set_hour_bcd_q <= set_hour_bcd_d;
         set_min_bcd_q  <= set_min_bcd_d;
         ch_done_q      <= ch_done_d;
         done_q         <= done_d;
         raw_sec_q      <= raw_sec_d;
         raw_min_q      <= raw_min_d;
         raw_hour_q     <= raw_hour_d;
         start_q        <= start_d;
         rw_q           <= rw_d;
         reg_addr_q     <= reg_addr_d;
         wdata_q        <= wdata_d;
         hours_q        <= hours_d;
         minutes_q      <= minutes_d;
         seconds_q      <= seconds_d;
         time_valid_q   <= time_valid_d;
         new_time_q     <= new_time_d;
         err_q          <= err_d;
      end
   end

   assign i2c_start    = start_q;
   assign i2c_rw       = rw_q;
   assign i2c_addr     = DS1307_ADDR;
   assign i2c_reg_addr = reg_addr_q;
   assign i2c_wdata    = wdata_q;
   assign hours        = hours_q;
   assign minutes      = minutes_q;
   assign seconds      = seconds_q;
   assign time_valid   = time_valid_q;
   assign new_time     = new_time_q;
   assign busy         = (state_q != ST_IDLE);
   assign err          = err_q;

endmodule

// File: tb/tb_rtc_time_reader.sv
// tb_rtc_time_reader: directed + randomized bench with an I2C master/RTC register model.
// Latency: n/a.
// Backpressure: BFM answers each start after a random 1..4 cycle delay, or never when muted.
module tb_rtc_time_reader;
   localparam int POLL = 300;
   localparam int TMO  = 60;

   logic       clk = 1'b0;
   logic       rst;
   logic       set_req;
   logic [4:0] set_hour;
   logic [5:0] set_min;
   logic       i2c_start;
   logic       i2c_rw;
   logic [6:0] i2c_addr;
   logic [7:0] i2c_reg_addr;
   logic [7:0] i2c_wdata;
   logic [7:0] i2c_rdata;
   logic       i2c_done;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       time_valid;
   logic       new_time;
   logic       busy;
   logic       err;

   rtc_time_reader #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .set_req(set_req), .set_hour(set_hour), .set_min(set_min),
      .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_reg_addr(i2c_reg_addr),
      .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata), .i2c_done(i2c_done),
      .hours(hours), .minutes(minutes), .seconds(seconds), .time_valid(time_valid),
      .new_time(new_time), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [6:0] dev;
      int         cyc;
   } txn_t;

   txn_t       log_q[$];
   logic [7:0] regs [3];
   bit         mute = 1'b0;
   int         done_cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: time value -> DS1307 register encoding; decoding is done by search.
   function automatic logic [7:0] enc(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [7:0] enc12(input int h);
      int h12;
      h12 = (h % 12 == 0) ? 12 : h % 12;
      return 8'h40 | ((h >= 12) ? 8'h20 : 8'h00) | enc(h12);
   endfunction

   function automatic bit ref_decode(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                                     output int hh, output int mm, output int ss);
      hh = -1; mm = -1; ss = -1;
      for (int v = 0; v < 60; v++) begin
         if (enc(v) == (s & 8'h7F)) ss = v;
         if (enc(v) == (m & 8'h7F)) mm = v;
      end
      for (int v = 0; v < 24; v++)
         if (enc(v) == h || enc12(v) == h) hh = v;
      return (hh >= 0) && (mm >= 0) && (ss >= 0);
   endfunction

   // I2C master + DS1307 model: logs every start, answers reads from regs.
   initial begin : bfm
      txn_t t;
      int   d;
      i2c_done  = 1'b0;
      i2c_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst && i2c_start) begin
            t.rw = i2c_rw; t.addr = i2c_reg_addr; t.wdata = i2c_wdata; t.dev = i2c_addr; t.cyc = cyc;
            log_q.push_back(t);
            if (!mute) begin
               d = $urandom_range(1, 4);
               repeat (d) @(negedge clk);
               i2c_rdata = i2c_rw ? regs[i2c_reg_addr[1:0]] : 8'h00;
               i2c_done  = 1'b1;
               done_cyc  = cyc;
               @(negedge clk);
               i2c_done  = 1'b0;
            end
         end
      end
   end

   task automatic wait_nt(input int bound, output bit seen, output int at);
      seen = 1'b0; at = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (new_time) begin seen = 1'b1; at = cyc; end
      end
   endtask

   task automatic check_time(input string tag, input int hh, input int mm, input int ss);
      check({tag, "_hours"}, 64'(hours), 64'(hh));
      check({tag, "_minutes"}, 64'(minutes), 64'(mm));
      check({tag, "_seconds"}, 64'(seconds), 64'(ss));
   endtask

   initial begin : main
      int  hh, mm, ss, at, base, d, eh, em, es;
      bit  ok, seen, nt_seen;
      logic [7:0] hb [3];

      rst = 1'b1; set_req = 1'b0; set_hour = '0; set_min = '0;
      regs[0] = 8'h45; regs[1] = 8'h30; regs[2] = 8'h12;
      repeat (3) @(negedge clk);
      check("rst_outputs", {hours, minutes, seconds, time_valid, new_time, busy, err, i2c_start,
                            i2c_rw, i2c_reg_addr, i2c_wdata}, 64'd0);
      check("rst_addr", 64'(i2c_addr), 64'h68);

      // First poll right out of reset.
      rst = 1'b0;
      @(negedge clk);
      check("issue_busy", {busy, i2c_start}, 64'b10);
      @(negedge clk);
      check("first_start", {i2c_start, i2c_rw, i2c_reg_addr}, {1'b1, 1'b1, 8'h00});
      @(negedge clk);
      check("start_one_cycle", 64'(i2c_start), 64'd0);
      wait_nt(200, seen, at);
      check("nt_first", 64'(seen), 64'd1);
      check("nt_latency", 64'(at - done_cyc), 64'd2);
      check_time("first", 12, 30, 45);
      check("first_valid_err", {time_valid, err}, 64'b10);
      @(negedge clk);
      check("nt_one_pulse", 64'(new_time), 64'd0);
      check("first_log_n", 64'(log_q.size()), 64'd3);
      if (log_q.size() >= 3)
         check("first_log", {log_q[0].rw, log_q[0].addr, log_q[1].rw, log_q[1].addr,
                             log_q[2].rw, log_q[2].addr, log_q[2].dev},
               {1'b1, 8'h00, 1'b1, 8'h01, 1'b1, 8'h02, 7'h68});

      // 12 h corner cases, then random times in either hour mode.
      hb[0] = 8'h72; hb[1] = 8'h52; hb[2] = 8'h67;
      for (int k = 0; k < 9; k++) begin
         regs[0] = enc($urandom_range(0, 59));
         regs[1] = enc($urandom_range(0, 59));
         if (k < 3) regs[2] = hb[k];
         else begin
            d = $urandom_range(0, 23);
            regs[2] = $urandom_range(0, 1) ? enc12(d) : enc(d);
         end
         ok = ref_decode(regs[0], regs[1], regs[2], hh, mm, ss);
         if (k == 0) check("h72_pm12", 64'(hh), 64'd12);
         if (k == 1) check("h52_am12", 64'(hh), 64'd0);
         if (k == 2) check("h67_pm7", 64'(hh), 64'd19);
         wait_nt(POLL + 100, seen, at);
         check($sformatf("rand%0d_nt", k), 64'(seen), 64'd1);
         check_time($sformatf("rand%0d", k), hh, mm, ss);
         check($sformatf("rand%0d_err", k), 64'(err), 64'd0);
      end
      eh = hh; em = mm; es = ss;

      // Bad BCD minutes: err, outputs retained, no new_time.
      regs[1] = 8'h6A;
      nt_seen = 1'b0;
      for (int i = 0; i < POLL + 100 && !err; i++) begin
         @(negedge clk);
         if (new_time) nt_seen = 1'b1;
      end
      check("badbcd_err", 64'(err), 64'd1);
      check("badbcd_no_nt", 64'(nt_seen), 64'd0);
      check_time("badbcd_hold", eh, em, es);
      regs[1] = enc(41);
      ok = ref_decode(regs[0], regs[1], regs[2], eh, em, es);
      wait_nt(POLL + 100, seen, at);
      check("recover_nt", 64'(seen), 64'd1);
      check_time("recover", eh, em, es);
      check("recover_err", 64'(err), 64'd0);

      // Time-set request arriving during a read.
      for (int i = 0; i < POLL + 100 && !busy; i++) @(negedge clk);
      base = log_q.size();
      set_req = 1'b1; set_hour = 5'd23; set_min = 6'd5;
      @(negedge clk);
      set_req = 1'b0;
      wait_nt(200, seen, at);
      check("set_read_nt", 64'(seen), 64'd1);
      check_time("set_read", eh, em, es);
      for (int i = 0; i < 300 && (log_q.size() < base + 6 || busy); i++) @(negedge clk);
      check("set_log_n", 64'(log_q.size()), 64'(base + 6));
      if (log_q.size() >= base + 6) begin
         check("set_w0", {log_q[base+3].rw, log_q[base+3].addr, log_q[base+3].wdata}, {1'b0, 8'h02, 8'h23});
         check("set_w1", {log_q[base+4].rw, log_q[base+4].addr, log_q[base+4].wdata}, {1'b0, 8'h01, 8'h05});
         check("set_w2", {log_q[base+5].rw, log_q[base+5].addr, log_q[base+5].wdata}, {1'b0, 8'h00, 8'h00});
         for (int j = base + 3; j < base + 6; j++)
            if (!log_q[j].rw && log_q[j].addr < 8'd3) regs[log_q[j].addr[1:0]] = log_q[j].wdata;
      end
      wait_nt(POLL + 100, seen, at);
      check("set_after_nt", 64'(seen), 64'd1);
      check_time("set_after", 23, 5, 0);

      // Master never answers: timeout, then retry on the next poll.
      mute = 1'b1;
      at = 0;
      for (int i = 0; i < POLL + TMO + 100 && !err; i++) begin
         @(negedge clk);
         at = cyc;
      end
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_busy", 64'(busy), 64'd0);
      d = (log_q.size() > 0) ? at - log_q[$].cyc : -1;
      check("tmo_window", 64'(d >= TMO && d <= TMO + 2), 64'd1);
      mute = 1'b0;
      wait_nt(POLL + 100, seen, at);
      check("tmo_retry_nt", 64'(seen), 64'd1);
      check("tmo_retry_err", 64'(err), 64'd0);
      check_time("tmo_retry", 23, 5, 0);

      // Halted oscillator on the first read after reset: one CH clear, no update.
      rst = 1'b1;
      regs[0] = 8'h80; regs[1] = 8'h15; regs[2] = 8'h09;
      repeat (2) @(negedge clk);
      check("rst2_valid", {time_valid, hours, minutes, seconds}, 64'd0);
      base = log_q.size();
      rst = 1'b0;
      nt_seen = 1'b0;
      for (int i = 0; i < 300 && (log_q.size() < base + 4 || busy); i++) begin
         @(negedge clk);
         if (new_time) nt_seen = 1'b1;
      end
      check("ch_no_nt", {nt_seen, time_valid}, 64'd0);
      check("ch_log_n", 64'(log_q.size()), 64'(base + 4));
      if (log_q.size() >= base + 4) begin
         check("ch_write", {log_q[base+3].rw, log_q[base+3].addr, log_q[base+3].wdata}, {1'b0, 8'h00, 8'h00});
         regs[0] = log_q[base+3].wdata;
      end
      wait_nt(POLL + 100, seen, at);
      check("ch_after_nt", 64'(seen), 64'd1);
      check_time("ch_after", 9, 15, 0);
      check("ch_after_valid", 64'(time_valid), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
